// File: rtl/zbus_master.sv
// zbus_master -- Z80 bus-cycle initiator.
//
// Turns a single-request command interface into Z80 machine cycles
// (opcode fetch with refresh, memory read/write, I/O read/write, interrupt
// acknowledge, nop). T-state boundaries come from the zpos/zneg clock-enable
// strobes. Everything runs on clk.
//
// Ports:
//   clk, rst_n       FPGA clock, asynchronous active-low reset
//   zpos, zneg       one-clk strobes for Z80 clock rising / falling edges
//   req              cycle request (level), sampled only when a cycle may start
//   cyc_type         0 opfetch, 1 memrd, 2 memwr, 3 iord, 4 iowr, 5 intack, 6/7 nop
//   addr_in, wdata   cycle address / write data, captured at acceptance
//   ireg             I register, upper byte of the refresh address
//   wait_n, din      Z80 WAIT input and bus data in
//   a, dout, data_oe address bus, data out and its output enable
//   mreq_n .. rfsh_n bus strobes
//   busy, done       cycle in progress / one-clk completion pulse
//   rdata, rreg      captured read data / 7-bit R register
module zbus_master (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        zpos,
    input  logic        zneg,
    input  logic        req,
    input  logic [2:0]  cyc_type,
    input  logic [15:0] addr_in,
    input  logic [7:0]  wdata,
    input  logic [7:0]  ireg,
    input  logic        wait_n,
    input  logic [7:0]  din,
    output logic [15:0] a,
    output logic [7:0]  dout,
    output logic        data_oe,
    output logic        mreq_n,
    output logic        iorq_n,
    output logic        rd_n,
    output logic        wr_n,
    output logic        m1_n,
    output logic        rfsh_n,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic [6:0]  rreg
);
    localparam logic [2:0] TY_OPF  = 3'd0;
    localparam logic [2:0] TY_MRD  = 3'd1;
    localparam logic [2:0] TY_MWR  = 3'd2;
    localparam logic [2:0] TY_IORD = 3'd3;
    localparam logic [2:0] TY_IOWR = 3'd4;
    localparam logic [2:0] TY_INTA = 3'd5;

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3, S_T4} state_t;

    state_t     state_reg, state_next;
    logic [2:0] type_reg, type_next;
    // Automatic wait states still to be entered in this cycle.
    logic [1:0] auto_reg, auto_next;
    logic       wait_smp_reg;

    logic       is_nop, is_rfsh, is_io, last_t, at_boundary, accept;
    logic       new_is_wr, new_is_m1;
    logic [1:0] new_auto;

    assign is_nop  = type_reg[2] & type_reg[1];
    assign is_rfsh = (type_reg == TY_OPF) || (type_reg == TY_INTA);
    assign is_io   = (type_reg == TY_IORD) || (type_reg == TY_IOWR);

    always_comb begin
        new_auto = 2'd0;
        if (cyc_type == TY_IORD || cyc_type == TY_IOWR) begin
            new_auto = 2'd1;
        end else if (cyc_type == TY_INTA) begin
            new_auto = 2'd2;
        end
        new_is_wr = (cyc_type == TY_MWR) || (cyc_type == TY_IOWR);
        new_is_m1 = (cyc_type == TY_OPF) || (cyc_type == TY_INTA);
    end

    // The current T-state is the final one of its cycle.
    always_comb begin
        last_t = 1'b0;
        case (state_reg)
            S_T1:    last_t = is_nop;
            S_T3:    last_t = !is_rfsh;
            S_T4:    last_t = 1'b1;
            default: last_t = 1'b0;
        endcase
    end

    assign at_boundary = (state_reg == S_IDLE) || last_t;
    assign accept      = zpos && at_boundary && req;

    always_comb begin
        state_next = state_reg;
        type_next  = type_reg;
        auto_next  = auto_reg;
        if (zpos) begin
            if (at_boundary) begin
                if (req) begin
                    state_next = S_T1;
                    type_next  = cyc_type;
                    auto_next  = new_auto;
                end else begin
                    state_next = S_IDLE;
                end
            end else begin
                case (state_reg)
                    S_T1: state_next = S_T2;
                    S_T2, S_TW: begin
                        // Automatic TWs first, then WAIT decides.
                        if (auto_reg != 2'd0) begin
                            state_next = S_TW;
                            auto_next  = auto_reg - 2'd1;
                        end else if (!wait_smp_reg) begin
                            state_next = S_TW;
                        end else begin
                            state_next = S_T3;
                        end
                    end
                    S_T3:    state_next = S_T4;
                    default: state_next = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            type_reg     <= 3'd0;
            auto_reg     <= 2'd0;
            wait_smp_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            type_reg  <= type_next;
            auto_reg  <= auto_next;
            // WAIT is only meaningful once the automatic TWs are used up.
            if (zneg && (state_reg == S_T2 || state_reg == S_TW) && auto_reg == 2'd0) begin
                wait_smp_reg <= wait_n;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a       <= 16'h0000;
            dout    <= 8'h00;
            data_oe <= 1'b0;
            mreq_n  <= 1'b1;
            iorq_n  <= 1'b1;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            m1_n    <= 1'b1;
            rfsh_n  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= 8'h00;
            rreg    <= 7'h00;
        end else begin
            done <= 1'b0;
            if (zpos) begin
                if (at_boundary) begin
                    if (last_t) begin
                        done    <= 1'b1;
                        data_oe <= 1'b0;
                        rfsh_n  <= 1'b1;
                        if (state_reg == S_T4) begin
                            rreg <= rreg + 7'd1;
                        end
                    end
                    // A new cycle overrides the end-of-cycle cleanup above.
                    if (accept) begin
                        a    <= addr_in;
                        m1_n <= !new_is_m1;
                        if (new_is_wr) begin
                            dout    <= wdata;
                            data_oe <= 1'b1;
                        end
                    end
                    busy <= accept;
                end else if (state_reg == S_T1) begin
                    if (is_io) begin
                        iorq_n <= 1'b0;
                        if (type_reg == TY_IORD) rd_n <= 1'b0;
                        else                     wr_n <= 1'b0;
                    end
                end else if (state_next == S_T3 && is_rfsh) begin
                    // Fetched byte is taken at T3 rise; refresh half begins.
                    rdata  <= din;
                    m1_n   <= 1'b1;
                    mreq_n <= 1'b1;
                    rd_n   <= 1'b1;
                    iorq_n <= 1'b1;
                    rfsh_n <= 1'b0;
                    a      <= {ireg, 1'b0, rreg};
                end
            end else if (zneg) begin
                case (state_reg)
                    S_T1: begin
                        if (type_reg == TY_OPF || type_reg == TY_MRD) begin
                            mreq_n <= 1'b0;
                            rd_n   <= 1'b0;
                        end else if (type_reg == TY_MWR) begin
                            mreq_n <= 1'b0;
                        end
                    end
                    S_T2: begin
                        if (type_reg == TY_MWR) wr_n <= 1'b0;
                    end
                    S_TW: begin
                        if (type_reg == TY_INTA && auto_reg == 2'd0) iorq_n <= 1'b0;
                    end
                    S_T3: begin
                        if (is_rfsh) begin
                            mreq_n <= 1'b0;
                        end else begin
                            if (type_reg == TY_MRD || type_reg == TY_IORD) rdata <= din;
                            mreq_n <= 1'b1;
                            iorq_n <= 1'b1;
                            rd_n   <= 1'b1;
                            wr_n   <= 1'b1;
                        end
                    end
                    S_T4:    mreq_n <= 1'b1;
                    default: ;
                endcase
            end
        end
    end
endmodule
